inner_product_requester: RTL

//  Initiator side of the PU read/write stream used by the inner-product layer. Issues
//  pu_rd_req to pull NUM_PE input operands per beat, multiplies them by a broadcast

---
 rtl/inner_product_requester.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/inner_product_requester.sv
`default_nettype none
// ============================================================================
// Module      : inner_product_requester
// Description : Initiator side of the PU read/write stream for an
//               inner-product layer. It pulls NUM_PE operands per read beat
//               and multiplies each lane by a broadcast weight taken from a
//               local KERNEL_LEN-entry buffer, accumulating the products.
//               After KERNEL_LEN beats it writes the NUM_PE results in one
//               strobe. This repeats num_outputs times per start, and then
//               done is pulsed.
// Ports       :
//   clk, reset          clock, synchronous active-high reset
//   start, num_outputs  job launch (IDLE only); write count latched on start
//   wt_wr_en/addr/data  weight buffer load port (IDLE only)
//   pu_rd_req/ready     read handshake; pu_data_in valid the cycle after req
//   pu_wr_req           one-cycle write strobe with pu_data_out
//   busy, done          job status
// Revision    : 1.0 - initial release
// ============================================================================
module inner_product_requester #(
  parameter int OP_WIDTH   = 16,
  parameter int NUM_PE     = 1,
  parameter int KERNEL_LEN = 9,
  parameter int CNT_WIDTH  = 16,
  localparam int DATA_WIDTH = OP_WIDTH * NUM_PE,
  localparam int ADDR_WIDTH = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_outputs,
  input  logic                  wt_wr_en,
  input  logic [ADDR_WIDTH-1:0] wt_wr_addr,
  input  logic [OP_WIDTH-1:0]   wt_wr_data,
  output logic                  pu_rd_req,
  input  logic                  pu_rd_ready,
  input  logic [DATA_WIDTH-1:0] pu_data_in,
  output logic                  pu_wr_req,
  output logic [DATA_WIDTH-1:0] pu_data_out,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_k;
  logic                  r_pipe_valid;
  logic [ADDR_WIDTH-1:0] r_pipe_k;
  logic [CNT_WIDTH-1:0]  r_out_cnt;
  logic [CNT_WIDTH-1:0]  r_num_outputs;
  logic [OP_WIDTH-1:0]   r_weight [KERNEL_LEN];

  logic                  w_last_beat;
  logic [CNT_WIDTH-1:0]  w_out_cnt_inc;
  logic [OP_WIDTH-1:0]   w_wt_sel;
  logic                  w_wt_addr_ok;

  assign w_last_beat   = (r_k == ADDR_WIDTH'(KERNEL_LEN - 1));
  assign w_out_cnt_inc = r_out_cnt + 1'b1;
  // Weight selected by the index that travelled with the beat, so it lines
  // up with the data arriving one cycle after the request.
  assign w_wt_sel      = r_weight[r_pipe_k];
  assign w_wt_addr_ok  = (32'(wt_wr_addr) < KERNEL_LEN);

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    pu_rd_req   = 1'b0;
    pu_wr_req   = 1'b0;
    done        = 1'b0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (num_outputs == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        // Intent to read is implied by being in READ; ready gates it.
        pu_rd_req = pu_rd_ready;
        if (pu_rd_ready && w_last_beat) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        pu_wr_req   = 1'b1;
        w_state_nxt = (w_out_cnt_inc == r_num_outputs) ? S_DONE : S_READ;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, beat index, beat pipeline and output counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_k           <= '0;
      r_pipe_valid  <= 1'b0;
      r_pipe_k      <= '0;
      r_out_cnt     <= '0;
      r_num_outputs <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pipe_valid <= pu_rd_req;
      r_pipe_k     <= r_k;
      if (r_state == S_IDLE && start) begin
        r_num_outputs <= num_outputs;
        r_out_cnt     <= '0;
      end
      if (pu_rd_req) begin
        r_k <= w_last_beat ? '0 : r_k + 1'b1;
      end
      if (r_state == S_WRITE) begin
        r_out_cnt <= w_out_cnt_inc;
        r_k       <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Weight buffer: survives reset; writable only while idle
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset && r_state == S_IDLE && wt_wr_en && w_wt_addr_ok) begin
      r_weight[wt_wr_addr] <= wt_wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Per-lane multiply-accumulate; all arithmetic wraps at OP_WIDTH bits
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
      logic [OP_WIDTH-1:0] r_acc;
      logic [OP_WIDTH-1:0] w_prod;

      assign w_prod = pu_data_in[i*OP_WIDTH +: OP_WIDTH] * w_wt_sel;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_acc <= '0;
        end else if (r_state == S_WRITE) begin
          r_acc <= '0;
        end else if (r_pipe_valid) begin
          r_acc <= r_acc + w_prod;
        end
      end

      assign pu_data_out[i*OP_WIDTH +: OP_WIDTH] = (r_state == S_WRITE) ? r_acc : '0;
    end
  endgenerate

endmodule
`default_nettype wire
